bin2bcd_seq: RTL
================

# bin2bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, "double dabble") that sits directly downstream of the Babbage difference circuit. It takes the 18-bit result `ans` on a `start`/`ready`/`done_tick` handshake and produces six packed BCD digits for the seven-segment display driver. One shift per clock keeps the datapath to six 4-bit adjust units and one shift register.

## Interface
- `BIN_W`, default 18: binary input width.
- `DIGITS`, default 6: BCD digits produced. Must satisfy 10^DIGITS > 2^BIN_W − 1.
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: request a conversion. Sampled only while `ready`=1.
- `bin` input `BIN_W`: binary value. Sampled on the edge that accepts `start`.
- `bcd` output 4·`DIGITS`: packed BCD result, digit 0 in [3:0].
- `ready` output 1: idle, able to accept `start`.
- `done_tick` output 1: one-cycle pulse when `bcd` is valid.

## Operation
- FSM states and transitions:
  - IDLE: if `start`, go to OP.
  - OP: after `BIN_W` shifts, go to DONE.
  - DONE: go to IDLE unconditionally.
- Entering OP (accept edge):
  - Load shift register with `bin`.
  - Clear working BCD register.
  - Set counter to `BIN_W`.
- Each OP cycle:
  - Every working digit ≥5 gets +3. Each digit's 4-bit result is in range 0–12, no carry out.
  - Then shift {bcd_work, bin_sr} left by 1.
  - Decrement the counter.
- Counter width is ⌈log2(`BIN_W`+1)⌉. It is unsigned and never wraps, because the decrement stops at 0.
- `bcd` output register:
  - Updated only on the OP→DONE edge.
  - Holds its value through IDLE until the next conversion completes.
- `ready`=1 only in IDLE.
- `done_tick`=1 only in DONE.
- `start` in OP or DONE is ignored. It is neither queued nor does it corrupt the in-flight value.
- `start` held high continuously retriggers on the first IDLE cycle after DONE, re-sampling `bin` there.
- `rst` asserted in any state, including mid-OP:
  - Next edge forces IDLE and clears all registers.
  - The in-flight conversion is abandoned and no `done_tick` is issued.
- `rst` and `start` in the same cycle: `rst` wins.

## Timing
- Reset values:
  - `bcd`=0, `ready`=1, `done_tick`=0.
  - State=IDLE, counter=0, shift registers=0.
- Call the accept edge E0.
- Edges E1…E`BIN_W` perform the shifts. Edge E`BIN_W` moves the state to DONE.
- `done_tick` and new `bcd` are visible in the cycle after E`BIN_W`. For defaults, that is the 19th cycle after E0.
- `ready` rises one edge later, at E`BIN_W`+1.
- Minimum start-to-start period is `BIN_W`+2 cycles (20 for defaults).
- Conversion time is fixed and independent of the data value.

## Configuration
- `BIN2BCD_BLANK_EN` defined:
  - Adds output `blank` [`DIGITS`−1:0], registered alongside `bcd`.
  - Bit k=1 when digit k and all higher digits are zero.
  - Bit 0 is always 0, so a zero result shows a single "0".
  - Reset value is all ones except bit 0.
- `BIN2BCD_BLANK_EN` undefined: port and logic are absent, and the interface is as listed above.

## Structure
- Package `bin2bcd_pkg` holds:
  - the state typedef (IDLE, OP, DONE);
  - default constants `BIN2BCD_BIN_W`=18 and `BIN2BCD_DIGITS`=6;
  - the counter width derived from `BIN_W`.
- Sub-module `bcd_digit_adj`:
  - Combinational, 4-bit in to 4-bit out, adds 3 when the input is ≥5.
  - Instantiated `DIGITS` times in a generate loop.
- The top module holds the FSM, counter, shift registers and output registers.

## Test plan
- Reset, then `bin`=0 with `start` pulse:
  - `done_tick` is high exactly 19 cycles after the accept edge.
  - `bcd`=0x000000 with no other `done_tick` pulse.
- `bin`=262143 → `bcd`=0x262143.
- `bin`=99999 → `bcd`=0x099999.
- Back-to-back `bin`=1 then `bin`=10 with `start` held high:
  - Results are 0x000001 then 0x000010.
  - Second `done_tick` occurs exactly 20 cycles after the first.
- Start `bin`=12345, pulse `start` again with `bin`=54321 at cycle 5:
  - Result is 0x012345.
  - The second request is ignored and only one `done_tick` is issued.
- Start `bin`=777, assert `rst` at cycle 8:
  - Next cycle shows `ready`=1 and `bcd`=0, with no `done_tick`.
  - A fresh `bin`=777 conversion then yields 0x000777.
  - With `BIN2BCD_BLANK_EN`, `blank`=6'b111000.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared types and constants for the sequential binary-to-BCD converter
package bin2bcd_pkg;

    localparam int BIN2BCD_BIN_W  = 18;
    localparam int BIN2BCD_DIGITS = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP   = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter must hold BIN_W itself, hence the +1.
    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

    localparam int BIN2BCD_CNT_W = cnt_width(BIN2BCD_BIN_W);

endpackage

// File: rtl/bin2bcd_if.sv
// rtl/bin2bcd_if.sv - start/ready/done_tick handshake bundle; optional blank lane under BIN2BCD_BLANK_EN
interface bin2bcd_if
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = BIN2BCD_BIN_W,
    parameter int DIGITS = BIN2BCD_DIGITS
);

    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ready;
    logic                  done_tick;

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0]     blank;

    modport master (
        output start, bin,
        input  bcd, ready, done_tick, blank
    );

    modport slave (
        input  start, bin,
        output bcd, ready, done_tick, blank
    );
`else
    modport master (
        output start, bin,
        input  bcd, ready, done_tick
    );

    modport slave (
        input  start, bin,
        output bcd, ready, done_tick
    );
`endif

endinterface

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - one BCD digit pre-shift correction (add 3 when the digit is 5 or more)
module bcd_digit_adj (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Largest input reachable in a valid conversion is 9, so 9+3=12 fits in 4 bits.
    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - double-dabble converter, one shift per clock; BIN2BCD_BLANK_EN adds leading-zero blanking
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = BIN2BCD_BIN_W,
    parameter int DIGITS = BIN2BCD_DIGITS
) (
    input  logic      clk,
    input  logic      rst,
    bin2bcd_if.slave  bus
);

    localparam int CNT_W = cnt_width(BIN_W);
    localparam int BCD_W = 4 * DIGITS;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_sr_q, bin_sr_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic [BCD_W-1:0]   work_adj;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               last_shift;
    logic               ready;
    logic               done_tick;

    assign last_shift = (state_q == ST_OP) && (cnt_q <= CNT_W'(1));

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (work_q[4*g +: 4]),
            .digit_o (work_adj[4*g +: 4])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_OP;
            ST_OP:   if (last_shift) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready     = 1'b0;
        done_tick = 1'b0;
        case (state_q)
            ST_IDLE: ready     = 1'b1;
            ST_DONE: done_tick = 1'b1;
            default: ;
        endcase
    end

    // The bit leaving the top digit is rotated into the binary LSB; it is always 0 for
    // a legal BIN_W/DIGITS pair and never reaches the BCD side within BIN_W shifts.
    always_comb begin
        cnt_d    = cnt_q;
        bin_sr_d = bin_sr_q;
        work_d   = work_q;
        bcd_d    = bcd_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    bin_sr_d = bus.bin;
                    work_d   = '0;
                    cnt_d    = CNT_W'(BIN_W);
                end
            end
            ST_OP: begin
                work_d   = {work_adj[BCD_W-2:0], bin_sr_q[BIN_W-1]};
                bin_sr_d = {bin_sr_q[BIN_W-2:0], work_adj[BCD_W-1]};
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                if (last_shift) bcd_d = work_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            bin_sr_q <= '0;
            work_q   <= '0;
            bcd_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            bin_sr_q <= bin_sr_d;
            work_q   <= work_d;
            bcd_q    <= bcd_d;
        end
    end

    assign bus.bcd       = bcd_q;
    assign bus.ready     = ready;
    assign bus.done_tick = done_tick;

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d, blank_next;

    // Walk from the most significant digit down; a digit blanks while everything above it is zero.
    always_comb begin
        logic hi_zero;
        hi_zero    = 1'b1;
        blank_next = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            hi_zero       = hi_zero && (work_d[4*k +: 4] == 4'd0);
            blank_next[k] = hi_zero;
        end
        blank_next[0] = 1'b0;
    end

    always_comb begin
        blank_d = blank_q;
        if (last_shift) blank_d = blank_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else begin
            blank_q <= blank_d;
        end
    end

    assign bus.blank = blank_q;
`endif

endmodule
